ir_nec_rx: RTL

IR_NEC_RX -- requirements
Module: ir_nec_rx

---
 rtl/ir_nec_rx_pkg.sv | 35 +++
 rtl/ir_tick_gen.sv | 25 ++
 rtl/ir_nec_rx.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ir_nec_rx_pkg.sv
// Shared definitions for the NEC IR receiver: FSM encoding and every
// protocol timing limit, all expressed in microseconds.
package ir_nec_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_L,
    LEAD_H,
    BIT_L,
    BIT_H
  } state_t;

  localparam int DUR_W = 14;
  typedef logic [DUR_W-1:0] dur_t;

  localparam dur_t DUR_MAX          = 14'd16383;
  localparam dur_t LEAD_L_MIN       = 14'd8000;
  localparam dur_t LEAD_L_MAX       = 14'd10000;
  localparam dur_t LEAD_H_START_MIN = 14'd4000;
  localparam dur_t LEAD_H_START_MAX = 14'd5000;
  localparam dur_t LEAD_H_REP_MIN   = 14'd2000;
  localparam dur_t LEAD_H_REP_MAX   = 14'd2500;
  localparam dur_t BIT_MARK_MIN     = 14'd400;
  localparam dur_t BIT_MARK_MAX     = 14'd720;
  localparam dur_t BIT0_SPACE_MIN   = 14'd400;
  localparam dur_t BIT0_SPACE_MAX   = 14'd800;
  localparam dur_t BIT1_SPACE_MIN   = 14'd1400;
  localparam dur_t BIT1_SPACE_MAX   = 14'd2000;
  localparam dur_t BIT_TIMEOUT      = 14'd12000;

  function automatic logic in_window(input dur_t d, input dur_t lo, input dur_t hi);
    return (d >= lo) && (d <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Divides the system clock down to a single-cycle pulse once per microsecond.
module ir_tick_gen #(
  parameter int CLK_MHZ = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_MHZ - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      o_tick <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      o_tick <= (cnt_q == LAST);
    end
  end

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame decoder: synchronises the demodulator output, times each
// mark/space in microseconds and walks leader, 32 data bits and repeat codes.
module ir_nec_rx
  import ir_nec_rx_pkg::*;
#(
  parameter int CLK_MHZ = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ir_rxb,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_repeat,
  output logic        o_err
);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic        fall_q;
  logic        rise_q;
  logic        tick;
  dur_t        dur_q;
  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q;
  logic [31:0] shift_q, shift_nxt;
  logic        shift_en, clr_bits, load_data;
  logic        valid_d, repeat_d, err_d;
  logic        is_one;

  ir_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (tick)
  );

  // Synchroniser idles high so reset release never looks like a mark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_ir_rxb};
      prev_q <= sync_q[1];
      fall_q <= prev_q & ~sync_q[1];
      rise_q <= ~prev_q & sync_q[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q <= '0;
    end else if (fall_q || rise_q) begin
      dur_q <= '0;
    end else if (tick && (dur_q != DUR_MAX)) begin
      dur_q <= dur_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_nxt = shift_q;
    shift_en  = 1'b0;
    clr_bits  = 1'b0;
    load_data = 1'b0;
    valid_d   = 1'b0;
    repeat_d  = 1'b0;
    err_d     = 1'b0;
    is_one    = in_window(dur_q, BIT1_SPACE_MIN, BIT1_SPACE_MAX);
    case (state_q)
      IDLE: begin
        if (fall_q) state_d = LEAD_L;
      end
      LEAD_L: begin
        if (rise_q)
          state_d = in_window(dur_q, LEAD_L_MIN, LEAD_L_MAX) ? LEAD_H : IDLE;
      end
      LEAD_H: begin
        if (fall_q) begin
          if (in_window(dur_q, LEAD_H_START_MIN, LEAD_H_START_MAX)) begin
            state_d  = BIT_L;
            clr_bits = 1'b1;
          end else if (in_window(dur_q, LEAD_H_REP_MIN, LEAD_H_REP_MAX)) begin
            state_d  = IDLE;
            repeat_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (dur_q > LEAD_H_START_MAX) begin
          state_d = IDLE;
        end
      end
      BIT_L: begin
        if (dur_q >= BIT_TIMEOUT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (rise_q) begin
          if (in_window(dur_q, BIT_MARK_MIN, BIT_MARK_MAX)) begin
            state_d = BIT_H;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      BIT_H: begin
        if (dur_q >= BIT_TIMEOUT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (fall_q) begin
          if (is_one || in_window(dur_q, BIT0_SPACE_MIN, BIT0_SPACE_MAX)) begin
            shift_en  = 1'b1;
            shift_nxt = {is_one, shift_q[31:1]};
            // The 32nd bit's closing edge is the stop mark, so the frame ends here.
            if (bit_cnt_q == 5'd31) begin
              state_d = IDLE;
              if ((shift_nxt[23:16] ^ shift_nxt[31:24]) == 8'hFF) begin
                load_data = 1'b1;
                valid_d   = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              state_d = BIT_L;
            end
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_repeat  <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      o_valid  <= valid_d;
      o_repeat <= repeat_d;
      o_err    <= err_d;
      if (clr_bits) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        shift_q   <= shift_nxt;
      end
      if (load_data) o_data <= shift_nxt;
    end
  end

endmodule
